// File: rtl/wb_pkg.sv
// wb_pkg: commit trace record type shared by the writeback trace block and its FIFO.
package wb_pkg;
  localparam logic [3:0] TRACE_WEN_ALL = 4'hF;
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trace_rec_t;
endpackage

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: circular FIFO of trace records; pointers carry a wrap bit to tell full from empty.
module wb_trace_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic       pop,
  input  trace_rec_t din,
  output trace_rec_t dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  trace_rec_t mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty = wr_ptr == rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/wb_commit_trace.sv
// wb_commit_trace: W-stage regfile write, buffered commit trace and retired counter.
// Define WB_TRACE_FIFO_EN for a DEPTH-entry trace FIFO; otherwise a single output register.
module wb_commit_trace
  import wb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             commit_validW,
  input  logic [31:0]      pcW,
  input  logic             regwriteW,
  input  logic [4:0]       writeregW,
  input  logic [31:0]      resultW,
  input  logic             flush_exceptionW,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             wb_stall_req,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [31:0]      trace_pc,
  output logic [3:0]       trace_wen,
  output logic [4:0]       trace_wnum,
  output logic [31:0]      trace_wdata,
  output logic [CNT_W-1:0] retired_cnt
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wb_commit_trace: DEPTH must be a power of two >= 2");
  end
  logic       live, accept, pop, full, wen_ok;
  trace_rec_t rec_in, head, rec_out;
  // Holding reset also blocks regfile writes from a stale W stage.
  assign live         = commit_validW & ~flush_exceptionW & resetn;
  assign wen_ok       = regwriteW & (writeregW != 5'd0);
  assign pop          = trace_valid & trace_ready;
  assign wb_stall_req = live & full & ~trace_ready;
  assign accept       = live & ~wb_stall_req;
  assign rf_we        = accept & wen_ok;
  assign rf_waddr     = writeregW;
  assign rf_wdata     = resultW;
  assign rec_in       = '{pc: pcW, wen: wen_ok ? TRACE_WEN_ALL : 4'h0,
                          wnum: wen_ok ? writeregW : 5'd0, wdata: wen_ok ? resultW : 32'd0};
`ifdef WB_TRACE_FIFO_EN
  logic empty;
  wb_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .resetn(resetn), .push(accept), .pop(pop),
    .din(rec_in), .dout(head), .full(full), .empty(empty)
  );
  assign trace_valid = ~empty;
`else
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      trace_valid <= 1'b0;
      head        <= '0;
    end else if (accept) begin
      trace_valid <= 1'b1;
      head        <= rec_in;
    end else if (pop) begin
      trace_valid <= 1'b0;
    end
  assign full = trace_valid;
`endif
  // Stale storage is masked so an empty buffer always presents zeros.
  assign rec_out     = trace_valid ? head : '0;
  assign trace_pc    = rec_out.pc;
  assign trace_wen   = rec_out.wen;
  assign trace_wnum  = rec_out.wnum;
  assign trace_wdata = rec_out.wdata;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) retired_cnt <= '0;
    else if (accept) retired_cnt <= retired_cnt + CNT_W'(1);
endmodule
